// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared types, response codes and byte-lane merge for the AXI-Lite register file
package axi_lite_pkg;

    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_COLLECT,
        W_COMMIT,
        W_RESP
    } wstate_t;

    // Replace only the byte lanes whose strobe bit is set
    function automatic logic [AXI_DATA_W-1:0] apply_wstrb(
        input logic [AXI_DATA_W-1:0] old_val,
        input logic [AXI_DATA_W-1:0] new_val,
        input logic [AXI_STRB_W-1:0] strb
    );
        logic [AXI_DATA_W-1:0] merged;
        merged = old_val;
        for (int b = 0; b < AXI_STRB_W; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_wr_collect.sv
// rtl/axi_lite_wr_collect.sv - independent AW/W acceptance into holding registers
module axi_lite_wr_collect
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    accept_en,
    input  logic                    clear,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ADDR_WIDTH-1:0]   held_addr,
    output logic [DATA_WIDTH-1:0]   held_data,
    output logic [DATA_WIDTH/8-1:0] held_strb,
    output logic                    both_held,
    output logic                    both_held_next
);

    logic aw_held;
    logic w_held;
    logic aw_hs;
    logic w_hs;

    // Ready is a function of registered state only; forced low while reset is asserted
    assign awready = rst_n & accept_en & ~aw_held;
    assign wready  = rst_n & accept_en & ~w_held;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    assign both_held      = aw_held & w_held;
    assign both_held_next = (aw_held | aw_hs) & (w_held | w_hs);

    // Latch each channel independently; the commit cycle releases both holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            held_addr <= '0;
            held_data <= '0;
            held_strb <= '0;
        end else if (clear) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                held_addr <= awaddr;
            end
            if (w_hs) begin
                w_held    <= 1'b1;
                held_data <= wdata;
                held_strb <= wstrb;
            end
        end
    end

endmodule

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - AXI4-Lite slave with parametrised register file and read-only status slots
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int                             ADDR_WIDTH = 12,
    parameter int                             DATA_WIDTH = 32,
    parameter int                             NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic                           BVALID,
    input  logic                           BREADY,
    output logic [1:0]                     BRESP,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    wstate_t                 wstate;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    logic [ADDR_WIDTH-1:0]   held_addr;
    logic [DATA_WIDTH-1:0]   held_data;
    logic [DATA_WIDTH/8-1:0] held_strb;
    logic                    both_held;
    logic                    both_held_next;

    logic [IDX_W-1:0]        widx;
    logic [IDX_W-1:0]        ridx;
    logic                    w_hit;
    logic                    rd_hit;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    ar_hs;
    logic                    unused_ok;

    assign unused_ok = ^{AWPROT, ARPROT, held_addr[1:0], ARADDR[1:0], both_held};

    axi_lite_wr_collect #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_collect (
        .clk            (clk),
        .rst_n          (rst_n),
        .accept_en      (wstate == W_COLLECT),
        .clear          (wstate == W_COMMIT),
        .awaddr         (AWADDR),
        .awvalid        (AWVALID),
        .awready        (AWREADY),
        .wdata          (WDATA),
        .wstrb          (WSTRB),
        .wvalid         (WVALID),
        .wready         (WREADY),
        .held_addr      (held_addr),
        .held_data      (held_data),
        .held_strb      (held_strb),
        .both_held      (both_held),
        .both_held_next (both_held_next)
    );

    assign widx = held_addr[ADDR_WIDTH-1:2];
    assign ridx = ARADDR[ADDR_WIDTH-1:2];

    // Write target is in range and not a status slot
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (widx == IDX_W'(i) && !RO_MASK[i]) begin
                w_hit = 1'b1;
            end
        end
    end

    // Read mux: status slots come straight from fabric, others from the array
    always_comb begin
        rd_hit  = 1'b0;
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ridx == IDX_W'(i)) begin
                rd_hit  = 1'b1;
                rd_word = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
            end
        end
    end

    // Flatten the register array onto the fabric-facing bus
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

    // Write FSM: collect both channels, commit for one cycle, then hold the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate   <= W_COLLECT;
            BVALID   <= 1'b0;
            BRESP    <= RESP_OKAY;
            wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RST_VAL[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            wr_pulse <= '0;
            case (wstate)
                W_COLLECT: begin
                    if (both_held_next) begin
                        wstate <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (widx == IDX_W'(i) && !RO_MASK[i]) begin
                            regs[i]     <= apply_wstrb(regs[i], held_data, held_strb);
                            wr_pulse[i] <= 1'b1;
                        end
                    end
                    BRESP  <= w_hit ? RESP_OKAY : RESP_SLVERR;
                    BVALID <= 1'b1;
                    wstate <= W_RESP;
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID <= 1'b0;
                        wstate <= W_COLLECT;
                    end
                end
                default: wstate <= W_COLLECT;
            endcase
        end
    end

    assign ARREADY = rst_n & ~RVALID;
    assign ar_hs   = ARVALID & ARREADY;

    // Read channel: capture data at the address handshake and hold it until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= RESP_OKAY;
        end else if (ar_hs) begin
            RVALID <= 1'b1;
            RDATA  <= rd_hit ? rd_word : '0;
            RRESP  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (RVALID && RREADY) begin
            RVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb/tb_axi_lite_regfile.sv - scoreboard bench for the AXI-Lite register file
module tb_axi_lite_regfile;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam logic [NR-1:0]    RO      = 16'h0008;
    localparam logic [NR*DW-1:0] RST_IMG = {{(NR-2){32'h0}}, 32'h0000_1111, 32'h0000_00A5};

    logic              clk = 1'b0;
    logic              rst_n;
    logic [AW-1:0]     AWADDR;
    logic [2:0]        AWPROT;
    logic              AWVALID;
    logic              AWREADY;
    logic [DW-1:0]     WDATA;
    logic [DW/8-1:0]   WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic              BVALID;
    logic              BREADY;
    logic [1:0]        BRESP;
    logic [AW-1:0]     ARADDR;
    logic [2:0]        ARPROT;
    logic              ARVALID;
    logic              ARREADY;
    logic              RVALID;
    logic              RREADY;
    logic [DW-1:0]     RDATA;
    logic [1:0]        RRESP;
    logic [NR*DW-1:0]  reg_out;
    logic [NR*DW-1:0]  status_in;
    logic [NR-1:0]     wr_pulse;

    int checks   = 0;
    int failures = 0;

    logic [1:0]    bq [$];
    logic [33:0]   rq [$];
    logic [31:0]   mdl [NR];
    int            pulse_cnt [NR];
    logic [NR-1:0]    ro_bits  = RO;
    logic [NR*DW-1:0] rst_bits = RST_IMG;

    axi_lite_regfile #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .RO_MASK    (RO),
        .RST_VAL    (RST_IMG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .AWADDR    (AWADDR),
        .AWPROT    (AWPROT),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .BRESP     (BRESP),
        .ARADDR    (ARADDR),
        .ARPROT    (ARPROT),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .reg_out   (reg_out),
        .status_in (status_in),
        .wr_pulse  (wr_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (wr_pulse[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mdl[i] = rst_bits[i*DW +: DW];
    endtask

    task automatic do_aw(input logic [AW-1:0] a, input int dly);
        int n;
        repeat (dly) @(posedge clk);
        #1;
        AWADDR  = a;
        AWVALID = 1'b1;
        n = 0;
        @(negedge clk);
        while (!AWREADY && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!AWREADY) check("aw_timeout", 0, 1);
        @(posedge clk);
        #1 AWVALID = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        int n;
        repeat (dly) @(posedge clk);
        #1;
        WDATA  = d;
        WSTRB  = s;
        WVALID = 1'b1;
        n = 0;
        @(negedge clk);
        while (!WREADY && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!WREADY) check("w_timeout", 0, 1);
        @(posedge clk);
        #1 WVALID = 1'b0;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int d_aw, input int d_w, input int stall);
        int idx;
        bit ok;
        int p_before;
        int n;
        idx = int'(a[AW-1:2]);
        ok  = (idx < NR) ? !ro_bits[idx] : 1'b0;
        bq.push_back(ok ? 2'b00 : 2'b10);
        p_before = (idx < NR) ? pulse_cnt[idx] : 0;
        if (ok) begin
            for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
        end
        fork
            do_aw(a, d_aw);
            do_w(d, s, d_w);
        join
        n = 0;
        @(negedge clk);
        while (!BVALID && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b_latency", n, 1);
        if (BVALID) begin
            for (int k = 0; k < stall; k++) begin
                check("b_stable", {BVALID, BRESP}, {1'b1, bq[0]});
                check("aw_w_ready_in_resp", {AWREADY, WREADY}, 2'b00);
                @(negedge clk);
            end
            check("bresp", BRESP, bq.pop_front());
            BREADY = 1'b1;
            @(posedge clk);
            #1 BREADY = 1'b0;
        end else begin
            void'(bq.pop_front());
        end
        if (idx < NR) begin
            check("wr_pulse_count", pulse_cnt[idx] - p_before, ok ? 1 : 0);
            check("reg_out_slice", reg_out[idx*DW +: DW], mdl[idx]);
        end
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int stall);
        int idx;
        int n;
        logic [33:0] exp;
        idx = int'(a[AW-1:2]);
        if (idx >= NR)          exp = {2'b10, 32'h0};
        else if (ro_bits[idx])  exp = {2'b00, status_in[idx*DW +: DW]};
        else                    exp = {2'b00, mdl[idx]};
        rq.push_back(exp);
        ARADDR  = a;
        ARVALID = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ARREADY && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ARREADY) check("ar_timeout", 0, 1);
        @(posedge clk);
        #1 ARVALID = 1'b0;
        @(negedge clk);
        check("r_latency", RVALID, 1);
        if (RVALID) begin
            for (int k = 0; k < stall; k++) begin
                check("r_stable", {RVALID, RRESP, RDATA}, {1'b1, rq[0]});
                check("ar_ready_in_resp", ARREADY, 0);
                @(negedge clk);
            end
            check("rresp_rdata", {RRESP, RDATA}, rq.pop_front());
            RREADY = 1'b1;
            @(posedge clk);
            #1 RREADY = 1'b0;
        end else begin
            void'(rq.pop_front());
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        AWADDR  = '0;
        AWPROT  = 3'b000;
        AWVALID = 1'b0;
        WDATA   = '0;
        WSTRB   = '0;
        WVALID  = 1'b0;
        BREADY  = 1'b0;
        ARADDR  = '0;
        ARPROT  = 3'b000;
        ARVALID = 1'b0;
        RREADY  = 1'b0;
        status_in = '0;
        status_in[3*DW +: DW] = 32'hCAFE_0003;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
        check("reset_valids", {BVALID, RVALID}, 2'b00);
        check("reset_resps_rdata", {BRESP, RRESP, RDATA}, '0);
        check("reset_wr_pulse", wr_pulse, '0);
        check("reset_reg_out", reg_out, RST_IMG);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        axi_read(12'h000, 0);
        axi_write(12'h004, 32'hDEAD_BEEF, 4'hF, 0, 3, 0);
        check("reg1_after_aw_first", reg_out[63:32], 32'hDEAD_BEEF);
        axi_write(12'h004, 32'h1234_5678, 4'hF, 3, 0, 0);
        check("reg1_after_w_first", reg_out[63:32], 32'h1234_5678);
        axi_write(12'h006, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
        axi_read(12'h004, 0);

        axi_write(12'h008, 32'h1122_3344, 4'hF, 0, 0, 0);
        axi_write(12'h008, 32'hAABB_CCDD, 4'b0101, 1, 1, 0);
        axi_read(12'h008, 0);
        check("reg2_strobe_merge", reg_out[95:64], 32'h11BB_33DD);

        axi_write(12'h00C, 32'h5555_AAAA, 4'hF, 0, 0, 0);
        axi_read(12'h00C, 0);
        check("ro_reg_out_untouched", reg_out[127:96], 32'h0);
        axi_write(12'h100, 32'h0BAD_0BAD, 4'hF, 0, 2, 0);
        axi_read(12'h100, 0);

        axi_write(12'h010, 32'hA5A5_5A5A, 4'hF, 0, 0, 5);
        axi_read(12'h010, 5);

        for (int i = 0; i < 4; i++) begin
            axi_write(12'(4 * (5 + i)), $urandom, 4'($urandom_range(0, 15)), i, 3 - i, 0);
            axi_read(12'(4 * (5 + i)), 0);
        end

        fork
            do_aw(12'h018, 0);
            do_w(32'h0000_0077, 4'hF, 0);
        join
        @(negedge clk);
        @(negedge clk);
        check("bvalid_before_reset", BVALID, 1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_resp_bvalid", BVALID, 0);
        check("reset_mid_resp_reg_out", reg_out, RST_IMG);
        check("reset_mid_resp_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        axi_read(12'h004, 0);
        axi_read(12'h018, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
- Parametrised AXI4-Lite slave with an internal register file; successor to the fixed single-FSM AXI-Lite slave.
- Independent AW/W acceptance, byte strobes, full read path, per-register read-only mode and SLVERR decode.
- Sits between the PS GP port and dataplane control/status logic.
- Exposes writable registers as a flat bus and captures read-only status from fabric.

Parameters:
- ADDR_WIDTH, 12, AXI address width; word index is addr[ADDR_WIDTH-1:2].
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- NUM_REGS, 16, number of 32-bit registers. Must be at most 2**(ADDR_WIDTH-2).
- RO_MASK, 0, NUM_REGS-bit mask. A set bit makes that register read-only: reads return status_in, writes are refused.
- RST_VAL, 0, NUM_REGS*DATA_WIDTH reset image for the writable registers.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- AWADDR  in  ADDR_WIDTH  write address
- AWPROT  in  3  ignored
- AWVALID  in  1
- AWREADY  out  1
- WDATA  in  DATA_WIDTH
- WSTRB  in  DATA_WIDTH/8
- WVALID  in  1
- WREADY  out  1
- BVALID  out  1
- BREADY  in  1
- BRESP  out  2
- ARADDR  in  ADDR_WIDTH
- ARPROT  in  3  ignored
- ARVALID  in  1
- ARREADY  out  1
- RVALID  out  1
- RREADY  in  1
- RDATA  out  DATA_WIDTH
- RRESP  out  2
- reg_out  out  NUM_REGS*DATA_WIDTH  current writable register contents; slice i is register i.
- status_in  in  NUM_REGS*DATA_WIDTH  read-only register sources, sampled on read.
- wr_pulse  out  NUM_REGS  one-cycle strobe for each committed write to register i.

Behaviour:
- Reset (async assert, sync deassert is handled externally):
  - AWREADY=WREADY=ARREADY=0 while rst_n is low.
  - BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0; wr_pulse=0.
  - reg_out=RST_VAL.
  - Any in-flight transaction is dropped.
- Write FSM has three states: W_COLLECT, W_COMMIT, W_RESP.
- W_COLLECT:
  - AWREADY=!aw_held and WREADY=!w_held.
  - Each handshake latches addr or data+strobe into a holding register and sets aw_held or w_held.
  - AW and W may arrive in the same cycle or in either order, any number of cycles apart.
  - When both are held after an edge, go to W_COMMIT.
- W_COMMIT (one cycle), updated at the next edge:
  - Decode idx=addr[ADDR_WIDTH-1:2]. Addr[1:0] is ignored.
  - If idx<NUM_REGS and RO_MASK[idx]=0: apply byte lanes where WSTRB[b]=1, set wr_pulse[idx]=1 for one cycle, BRESP=OKAY(00).
  - Otherwise (out of range or read-only): no register change, no pulse, BRESP=SLVERR(10).
  - WSTRB=0 on a valid register gives OKAY, no data change, and the pulse still fires.
  - Clear the held flags, set BVALID=1, go to W_RESP.
- W_RESP:
  - BVALID and BRESP are held stable until BREADY. Return to W_COLLECT on the edge where BREADY is high.
  - AWREADY and WREADY stay 0 in W_COMMIT and W_RESP.
- Write latency with BREADY tied high: last handshake at edge N, register updated at N+1, BVALID high in cycle N+1..N+2. Peak rate is one write per 3 cycles.
- Read path:
  - ARREADY=!RVALID.
  - On AR handshake at edge N, RVALID, RDATA and RRESP are registered at edge N and visible the next cycle.
  - RW register: RDATA=reg_out slice. RO register: RDATA=status_in slice sampled at edge N.
  - Out of range: RDATA=0, RRESP=SLVERR.
  - RVALID, RDATA and RRESP are held stable until RREADY. RVALID clears on that edge.
  - A new AR is accepted the following cycle, giving peak rate one read per 2 cycles.
- Simultaneous read and write of the same register in the same edge: the read returns the pre-write value.
- The read and write paths are fully independent and never stall each other.
- AXI rule: VALID-to-READY has no combinational dependency. READY depends only on state and held flags.

Decomposition:
- Package axi_lite_pkg:
  - typedef resp_t and constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - enum wstate_t {W_COLLECT, W_COMMIT, W_RESP}.
  - function apply_wstrb(old, new, strb).
- One sub-module, axi_lite_wr_collect, holds the AW/W holding registers and held flags. It outputs held address, data, strobe and a both_held signal.
- Decode and the register array live in the top.

Test Plan:
- Reset then read reg 0 with RST_VAL[31:0]=0x0000_00A5 -> RVALID one cycle after AR, RDATA=0x0000_00A5, RRESP=00.
- AW at 0x004 in cycle 0, W 0xDEADBEEF/strb 0xF in cycle 3 -> reg_out[63:32]=0xDEADBEEF, wr_pulse[1] for exactly 1 cycle, BRESP=00. Repeat with W before AW: same result.
- Write 0x11223344 to reg 2 then write 0xAABBCCDD with WSTRB=0b0101 -> readback 0x11BB33DD.
- RO_MASK bit 3 set, status_in reg3=0xCAFE0003; write reg 3 -> BRESP=10, no pulse; read -> 0xCAFE0003, RRESP=00. Access 0x100 with NUM_REGS=16 -> SLVERR on both channels, RDATA=0.
- Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID, BRESP/RDATA stable, AWREADY=WREADY=ARREADY=0 throughout. Assert rst_n low mid-W_RESP -> BVALID=0 immediately, reg_out=RST_VAL.
